// File: rtl/curve_point_serializer_if.sv
// Point serializer handshake bundle: upstream point input, downstream word stream, status.
interface curve_point_serializer_if #(
    parameter int WORD_W = 32
) ();
    logic [511:0]        in_point;
    logic                in_valid;
    logic                in_ready;
    logic [WORD_W-1:0]   out_data;
    logic                out_valid;
    logic                out_ready;
    logic                out_last;
    logic                busy;

    modport slave (
        input  in_point, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last, busy
    );

    modport master (
        output in_point, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last, busy
    );
endinterface

// File: rtl/curve_point_serializer.sv
// Streams a 512b curve point {x,y} as WORD_W-bit words, x then y, most-significant word first.
// Define POINT_SER_SEC1_HDR_EN to prefix each point with a SEC1 uncompressed tag word (0x04).
module curve_point_serializer #(
    parameter int WORD_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    curve_point_serializer_if.slave    bus
);
    localparam int NWORDS = 2 * 256 / WORD_W;
`ifdef POINT_SER_SEC1_HDR_EN
    localparam int TOTAL  = NWORDS + 1;
`else
    localparam int TOTAL  = NWORDS;
`endif
    localparam int CNT_W  = $clog2(TOTAL);
    localparam int IDX_W  = $clog2(NWORDS);

    typedef enum logic {IDLE, SEND} state_e;

    state_e                         state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [511:0]                   hold_q, hold_d;

    logic [NWORDS-1:0][WORD_W-1:0]  hold_words;
    logic [IDX_W-1:0]               widx;
    logic [WORD_W-1:0]              word;
    logic                           busy, is_last;

    // {x,y} packed with x on top, so word 0 of the stream is the highest-indexed slice.
    assign hold_words = hold_q;
    assign busy       = (state_q == SEND);
    assign is_last    = (cnt_q == CNT_W'(TOTAL - 1));

`ifdef POINT_SER_SEC1_HDR_EN
    assign widx = IDX_W'(cnt_q - CNT_W'(1));
    assign word = (cnt_q == '0) ? WORD_W'(8'h04) : hold_words[IDX_W'(NWORDS - 1) - widx];
`else
    assign widx = IDX_W'(cnt_q);
    assign word = hold_words[IDX_W'(NWORDS - 1) - widx];
`endif

    // All outputs decode registered state only; out_ready never reaches in_ready.
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = busy;
    assign bus.out_valid = busy;
    assign bus.out_last  = busy & is_last;
    assign bus.out_data  = busy ? word : '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    hold_d  = bus.in_point;
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (bus.out_ready) begin
                    if (is_last) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
        end
    end
endmodule
